// File: rtl/round_robin_quantum_timer_if.sv
// round_robin_quantum_timer_if
//   Handshake bundle between a scheduler and the round-robin quantum timer.
//   Parameters: CNT_W (quantum/counter width), PID_W (process-ID width).
//   master modport: scheduler side (drives start/pid_in/quantum_in/block/
//                   yield/irq_ack, observes the status outputs).
//   slave modport : timer side (the reverse).
//   Signals:
//     start, pid_in, quantum_in  - request a new time slice
//     block, yield               - suspend counting / give up the CPU early
//     irq_ack                    - clears the sticky slice-end interrupt
//     pid_out, running           - current owner and RUN/HOLD indication
//     count_out, remaining       - elapsed / left cycles of the slice
//     expire, cause, irq         - slice-end pulse, reason, sticky interrupt
interface round_robin_quantum_timer_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned PID_W = 5
);
   logic             start;
   logic [PID_W-1:0] pid_in;
   logic [CNT_W-1:0] quantum_in;
   logic             block;
   logic             yield;
   logic             irq_ack;
   logic [PID_W-1:0] pid_out;
   logic             running;
   logic [CNT_W-1:0] count_out;
   logic [CNT_W-1:0] remaining;
   logic             expire;
   logic             cause;
   logic             irq;

   modport master (
      output start, pid_in, quantum_in, block, yield, irq_ack,
      input  pid_out, running, count_out, remaining, expire, cause, irq
   );

   modport slave (
      input  start, pid_in, quantum_in, block, yield, irq_ack,
      output pid_out, running, count_out, remaining, expire, cause, irq
   );
endinterface

// File: rtl/round_robin_quantum_timer.sv
// round_robin_quantum_timer
//   Time-slice timer for a round-robin scheduler. A slice starts on `start`,
//   latches the owning PID and the quantum (quantum_in, or DEF_QUANTUM when
//   quantum_in is 0) and counts unblocked cycles until the quantum is used up
//   or the process yields. `block` freezes the count (HOLD state).
//   Ports:
//     clk    - clock, rising-edge
//     reset  - asynchronous active-low reset
//     bus    - round_robin_quantum_timer_if.slave (see interface header)
//   Parameters: CNT_W, PID_W, DEF_QUANTUM (1..2^CNT_W-1), IDLE_PID.
//   Optional feature: define RR_TIMER_IRQ_EN to enable the sticky irq output
//   (set by expire, cleared by irq_ack, set wins). Without it irq is tied 0
//   and irq_ack is ignored.
module round_robin_quantum_timer #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned PID_W       = 5,
   parameter int unsigned DEF_QUANTUM = 30,
   parameter int unsigned IDLE_PID    = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   round_robin_quantum_timer_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEF_QUANTUM);
   localparam logic [PID_W-1:0] IDLE_P = PID_W'(IDLE_PID);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] quant_q, quant_d;
   logic [PID_W-1:0] pid_q, pid_d;
   logic             expire_q, expire_d;
   logic             cause_q, cause_d;
   logic [CNT_W-1:0] count_inc;
   logic [CNT_W-1:0] quant_sel;

   // count_q < quant_q whenever this is used, so it cannot wrap.
   assign count_inc = count_q + 1'b1;
   assign quant_sel = (bus.quantum_in == '0) ? DEF_Q : bus.quantum_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         quant_q  <= DEF_Q;
         pid_q    <= IDLE_P;
         expire_q <= 1'b0;
         cause_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         quant_q  <= quant_d;
         pid_q    <= pid_d;
         expire_q <= expire_d;
         cause_q  <= cause_d;
      end
   end

   // expire is asserted on every transition into DONE, so the registered
   // copy is high for exactly the single DONE cycle.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      quant_d  = quant_q;
      pid_d    = pid_q;
      expire_d = 1'b0;
      cause_d  = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (bus.start) begin
               state_d = ST_RUN;
               pid_d   = bus.pid_in;
               quant_d = quant_sel;
            end
         end
         ST_RUN: begin
            if (bus.yield) begin
               state_d  = ST_DONE;
               cause_d  = 1'b1;
               expire_d = 1'b1;
            end else if (count_inc == quant_q) begin
               state_d  = ST_DONE;
               cause_d  = 1'b0;
               count_d  = quant_q;
               expire_d = 1'b1;
            end else if (bus.block) begin
               state_d = ST_HOLD;
            end else begin
               count_d = count_inc;
            end
         end
         ST_HOLD: begin
            if (bus.yield) begin
               state_d  = ST_DONE;
               cause_d  = 1'b1;
               expire_d = 1'b1;
            end else if (!bus.block) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            count_d = '0;
            if (bus.start) begin
               state_d = ST_RUN;
               pid_d   = bus.pid_in;
               quant_d = quant_sel;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   logic run_hold;
   assign run_hold = (state_q == ST_RUN) || (state_q == ST_HOLD);

   assign bus.pid_out   = (state_q == ST_IDLE) ? IDLE_P : pid_q;
   assign bus.running   = run_hold;
   assign bus.count_out = count_q;
   assign bus.remaining = run_hold ? (quant_q - count_q) : '0;
   assign bus.expire    = expire_q;
   assign bus.cause     = cause_q;

`ifdef RR_TIMER_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else if (expire_q) begin
         irq_q <= 1'b1;
      end else if (bus.irq_ack) begin
         irq_q <= 1'b0;
      end
   end

   assign bus.irq = irq_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = bus.irq_ack;
   assign bus.irq        = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_quantum_timer.sv
// tb_round_robin_quantum_timer
//   Directed scoreboard bench for round_robin_quantum_timer. Each slice the
//   stimulus starts pushes its expected end (pid, cause, final count, cycle
//   number of the expire pulse); the monitor pops one entry on every expire
//   pulse. Inline checks cover reset, HOLD, back-to-back slices and irq.
module tb_round_robin_quantum_timer;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned PID_W = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      int pid;
      int cause;
      int cnt;
      int cyc;
   } exp_t;

   exp_t sb[$];

   round_robin_quantum_timer_if #(.CNT_W(CNT_W), .PID_W(PID_W)) bus ();

   round_robin_quantum_timer #(
      .CNT_W       (CNT_W),
      .PID_W       (PID_W),
      .DEF_QUANTUM (30),
      .IDLE_PID    (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every expire pulse must match the oldest expected slice end.
   always @(negedge clk) begin
      exp_t e;
      if (bus.expire === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_expire", 32'(bus.expire), 0);
         end else begin
            e = sb.pop_front();
            chk("exp_pid", 32'(bus.pid_out), e.pid);
            chk("exp_cause", 32'(bus.cause), e.cause);
            chk("exp_count", 32'(bus.count_out), e.cnt);
            chk("exp_cycle", cyc, e.cyc);
            chk("exp_remaining", 32'(bus.remaining), 0);
            chk("exp_running", 32'(bus.running), 0);
`ifndef RR_TIMER_IRQ_EN
            chk("irq_tied0", 32'(bus.irq), 0);
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic push(input int pid, input int cause, input int cnt, input int at);
      exp_t e;
      e.pid = pid; e.cause = cause; e.cnt = cnt; e.cyc = at;
      sb.push_back(e);
   endtask

   // Presents a one-cycle start; returns the cycle index before the sampling edge.
   task automatic begin_slice(input int pid, input int q, output int c);
      c              = cyc;
      bus.start      = 1'b1;
      bus.pid_in     = PID_W'(pid);
      bus.quantum_in = CNT_W'(q);
      tick();
      bus.start      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int c;
      bus.start      = 1'b0;
      bus.pid_in     = '0;
      bus.quantum_in = '0;
      bus.block      = 1'b0;
      bus.yield      = 1'b0;
      bus.irq_ack    = 1'b0;

      // Reset state
      #2;
      chk("rst_pid", 32'(bus.pid_out), 0);
      chk("rst_running", 32'(bus.running), 0);
      chk("rst_count", 32'(bus.count_out), 0);
      chk("rst_remaining", 32'(bus.remaining), 0);
      chk("rst_expire", 32'(bus.expire), 0);
      chk("rst_cause", 32'(bus.cause), 0);
      chk("rst_irq", 32'(bus.irq), 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // PID 7, quantum 4: four RUN cycles then DONE
      push(7, 0, 4, cyc + 5);
      begin_slice(7, 4, c);
      @(negedge clk);
      chk("q4_pid_run", 32'(bus.pid_out), 7);
      chk("q4_running", 32'(bus.running), 1);
      chk("q4_remaining", 32'(bus.remaining), 4);
      wait_cyc(c + 6);
      @(negedge clk);
      chk("q4_pid_idle", 32'(bus.pid_out), 0);
      chk("q4_idle_running", 32'(bus.running), 0);
      chk("q4_idle_expire", 32'(bus.expire), 0);

      // quantum_in 0 selects the default of 30
      tick();
      push(12, 0, 30, cyc + 31);
      begin_slice(12, 0, c);
      @(negedge clk);
      chk("def_remaining", 32'(bus.remaining), 30);
      wait_cyc(c + 32);

      // quantum 10, block for 5 cycles once count reaches 3
      push(4, 0, 10, cyc + 17);
      begin_slice(4, 10, c);
      wait_cyc(c + 4);
      bus.block = 1'b1;
      wait_cyc(c + 8);
      @(negedge clk);
      chk("hold_count", 32'(bus.count_out), 3);
      chk("hold_running", 32'(bus.running), 1);
      chk("hold_remaining", 32'(bus.remaining), 7);
      tick();
      bus.block = 1'b0;
      wait_cyc(c + 18);

      // yield at count 2 of quantum 10 (irq_ack toggled to show it is harmless)
      push(2, 1, 2, cyc + 4);
      begin_slice(2, 10, c);
      wait_cyc(c + 3);
      bus.yield   = 1'b1;
      bus.irq_ack = 1'b1;
      tick();
      bus.yield   = 1'b0;
      bus.irq_ack = 1'b0;
      wait_cyc(c + 5);

      // yield and block together: yield wins
      push(17, 1, 1, cyc + 3);
      begin_slice(17, 10, c);
      wait_cyc(c + 2);
      bus.yield = 1'b1;
      bus.block = 1'b1;
      tick();
      bus.yield = 1'b0;
      bus.block = 1'b0;
      wait_cyc(c + 4);

      // smallest quantum
      push(31, 0, 1, cyc + 2);
      begin_slice(31, 1, c);
      wait_cyc(c + 3);

      // start held through RUN (ignored) and DONE (back-to-back slice)
      c = cyc;
      push(3, 0, 2, c + 3);
      push(9, 0, 2, c + 6);
      bus.start      = 1'b1;
      bus.pid_in     = 5'd3;
      bus.quantum_in = 8'd2;
      tick();
      bus.pid_in = 5'd9;
      wait_cyc(c + 4);
      bus.start = 1'b0;
      @(negedge clk);
      chk("b2b_pid", 32'(bus.pid_out), 9);
      chk("b2b_running", 32'(bus.running), 1);
      chk("b2b_count", 32'(bus.count_out), 0);
      wait_cyc(c + 7);

      // asynchronous reset in the middle of a slice
      begin_slice(5, 10, c);
      tick(); tick();
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("arst_pid", 32'(bus.pid_out), 0);
      chk("arst_running", 32'(bus.running), 0);
      chk("arst_count", 32'(bus.count_out), 0);
      chk("arst_expire", 32'(bus.expire), 0);
      tick();
      c              = cyc;
      bus.start      = 1'b1;
      bus.pid_in     = 5'd6;
      bus.quantum_in = 8'd2;
      push(6, 0, 2, c + 3);
      #2 reset = 1'b1;
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      chk("post_rst_pid", 32'(bus.pid_out), 6);
      chk("post_rst_running", 32'(bus.running), 1);
      wait_cyc(c + 4);

`ifdef RR_TIMER_IRQ_EN
      // clear irq, then ack coincident with expire must leave irq set
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      @(negedge clk);
      chk("irq_cleared", 32'(bus.irq), 0);
      tick();
      push(1, 0, 2, cyc + 3);
      begin_slice(1, 2, c);
      wait_cyc(c + 3);
      bus.irq_ack = 1'b1;
      tick();
      @(negedge clk);
      chk("irq_set_wins", 32'(bus.irq), 1);
      tick();
      bus.irq_ack = 1'b0;
      @(negedge clk);
      chk("irq_ack_clears", 32'(bus.irq), 0);
`else
      @(negedge clk);
      chk("irq_disabled", 32'(bus.irq), 0);
`endif

      tick(); tick();
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/round_robin_quantum_timer.md
ROUND_ROBIN_QUANTUM_TIMER -- requirements
Module: round_robin_quantum_timer

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set quantum/counter width in bits.
REQ-002 Parameter PID_W, default 5, SHALL set process-ID width.
REQ-003 Parameter DEF_QUANTUM, default 30, SHALL be the quantum used when quantum_in is 0; range 1..2^CNT_W-1.
REQ-004 Parameter IDLE_PID, default 0, SHALL be the PID driven when no process owns the CPU.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin a time slice for pid_in.
REQ-008 pid_in  input  PID_W  process to be scheduled.
REQ-009 quantum_in  input  CNT_W  slice length in cycles; 0 selects DEF_QUANTUM.
REQ-010 block  input  1  suspend counting, e.g. process waiting on I/O.
REQ-011 yield  input  1  running process gives up the CPU early.
REQ-012 irq_ack  input  1  clears irq.
REQ-013 pid_out  output  PID_W  owning PID, or IDLE_PID.
REQ-014 running  output  1  high in RUN and HOLD.
REQ-015 count_out  output  CNT_W  elapsed unblocked cycles in current slice.
REQ-016 remaining  output  CNT_W  quantum minus count_out; 0 outside RUN/HOLD.
REQ-017 expire  output  1  one-cycle pulse when a slice ends.
REQ-018 cause  output  1  reason for last slice end: 0 quantum exhausted, 1 yield; held until next end.
REQ-019 irq  output  1  sticky slice-end interrupt (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE, RUN, HOLD, DONE; encoding free.
REQ-021 IDLE: start=1 -> RUN; latch pid_in; latch quantum (quantum_in, or DEF_QUANTUM if 0); count=0. Otherwise stay.
REQ-022 RUN, priority yield > expiry > block: yield=1 -> DONE, cause=1; else count+1==quantum -> DONE, cause=0, count=quantum; else block=1 -> HOLD, count unchanged; else count+1.
REQ-023 HOLD: count frozen; yield=1 -> DONE, cause=1; block=0 -> RUN (counting resumes next cycle); else stay.
REQ-024 DONE: lasts exactly one cycle, expire=1; start=1 -> RUN with fresh latch as REQ-021 (back-to-back slice); else -> IDLE.
REQ-025 start SHALL be ignored in RUN and HOLD; no preemption by a new start.
REQ-026 pid_out SHALL equal latched PID in RUN, HOLD and DONE; IDLE_PID in IDLE.
REQ-027 Quantum of Q SHALL give exactly Q RUN cycles (block-free) from the first RUN cycle to DONE; Q=1 -> DONE on next edge.
REQ-028 Counter SHALL never wrap; count_out <= quantum always.
REQ-029 Outputs other than pid_out, running, remaining SHALL be registered.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, count 0, latched PID IDLE_PID, latched quantum DEF_QUANTUM, expire 0, cause 0, irq 0.
REQ-031 Reset mid-slice SHALL abort the slice with no expire pulse; first post-release edge honours start.

Configuration
REQ-032 Macro RR_TIMER_IRQ_EN defined: irq set on any cycle expire=1, cleared by irq_ack; set wins over simultaneous ack.
REQ-033 Macro undefined: irq tied 0, irq_ack ignored; ports remain present.

Verification
REQ-034 start, pid_in=7, quantum_in=4, no block -> pid_out=7 for 4 RUN cycles + DONE, expire pulse 1 cycle, cause=0, then pid_out=0.
REQ-035 quantum_in=0 -> 30 RUN cycles to expire; count_out reaches 30, remaining 0 in DONE.
REQ-036 quantum 10, block for 5 cycles after 3 counts -> count_out holds 3, expire 15+ cycles after start (10 counting), running stays 1.
REQ-037 yield at count 2 of quantum 10 -> DONE next edge, cause=1; yield and block together at same cycle -> cause=1.
REQ-038 start held high through DONE with pid_in=9 -> RUN for PID 9 immediately after DONE, no IDLE cycle.
REQ-039 reset low mid-slice -> pid_out=0, running=0 asynchronously, no expire; with RR_TIMER_IRQ_EN, irq_ack coincident with expire leaves irq=1.
